// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO data-side bridge.
//   IO_BASE     : addr[31:12] value that selects the peripheral region
//   OFF_*       : byte offsets of the peripheral registers inside that region
//   NUM_DIGITS  : number of scanned 7-segment digits
//   digit_e     : scan-FSM state, one state per lit digit
//   hex_to_seg  : hex nibble -> active-low {g,f,e,d,c,b,a}
package mmio_pkg;

  localparam logic [19:0] IO_BASE    = 20'hFFFFF;
  localparam logic [11:0] OFF_DIG    = 12'h000;
  localparam logic [11:0] OFF_TIMER  = 12'h020;
  localparam logic [11:0] OFF_LED    = 12'h060;
  localparam logic [11:0] OFF_SW     = 12'h070;
  localparam int          NUM_DIGITS = 8;

  typedef enum logic [2:0] {
    DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7
  } digit_e;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an 8-digit 7-segment display.
//   clk, rst_n  : clock, synchronous active-low reset
//   dig_i[31:0] : 8 hex nibbles, nibble k is shown on digit k
//   seg_en_o    : digit enables, active-low, one digit lit at a time
//   seg_o       : {dp,g,f,e,d,c,b,a}, active-low, dp always off
// Each digit stays lit for SCAN_DIV clk cycles, order 0..7 then wrap.
module seg7_scan
  import mmio_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dig_i,
  output logic [7:0]  seg_en_o,
  output logic [7:0]  seg_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_e        state_q, state_d;
  logic [3:0]    nib [NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = dig_i[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= DIG0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    state_d = state_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = digit_e'(state_q + 3'd1);  // DIG7 wraps to DIG0
    end
  end

  // Outputs follow the DIG word combinationally so a new value shows
  // on the lit digit right after the write edge.
  assign seg_en_o = ~(8'h01 << state_q);
  assign seg_o    = {1'b1, hex_to_seg(nib[state_q])};

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU MEM-stage data bus -> data RAM / on-board peripherals.
//   clk, rst_n          : clock, synchronous active-low reset
//   addr_i/wdata_i/we_i : word access from the CPU (addr_i[1:0] ignored)
//   rdata_o             : zero-latency load data back to the CPU
//   ram_*               : combinational data RAM interface
//   sw_i / led_o        : switches (async, synchronised) / LEDs
//   seg_en_o / seg_o    : scanned 7-segment display, active-low
// IO region is addr[31:12] == IO_BASE: DIG, TIMER, LED (R/W), SW (R).
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int RAM_AW    = 16,
  parameter int SCAN_DIV  = 50000,
  parameter int TIMER_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              we_i,
  output logic [31:0]       rdata_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic              ram_we_o,
  input  logic [31:0]       ram_rdata_i,
  input  logic [23:0]       sw_i,
  output logic [23:0]       led_o,
  output logic [7:0]        seg_en_o,
  output logic [7:0]        seg_o
);

  localparam logic [31:0] TDIV_LAST = 32'(TIMER_DIV - 1);

  logic        io_sel, io_wr, tick;
  logic [9:0]  word_off;
  logic [31:0] dig_q, dig_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] tpre_q, tpre_d;
  logic [23:0] led_q, led_d;
  logic [23:0] sw_meta_q, sw_meta_d;
  logic [23:0] sw_sync_q, sw_sync_d;
  logic        unused_byte_sel;

  assign unused_byte_sel = ^addr_i[1:0];

  assign io_sel   = (addr_i[31:12] == IO_BASE);
  assign io_wr    = we_i & io_sel;
  assign word_off = addr_i[11:2];

  assign ram_addr_o  = addr_i[RAM_AW+1:2];
  assign ram_wdata_o = wdata_i;
  assign ram_we_o    = we_i & ~io_sel;

  // Loads see register state from before the current edge.
  always_comb begin
    rdata_o = 32'h0;
    if (!io_sel) begin
      rdata_o = ram_rdata_i;
    end else begin
      case (word_off)
        OFF_DIG[11:2]:   rdata_o = dig_q;
        OFF_TIMER[11:2]: rdata_o = timer_q;
        OFF_LED[11:2]:   rdata_o = {8'h0, led_q};
        OFF_SW[11:2]:    rdata_o = {8'h0, sw_sync_q};
        default:         rdata_o = 32'h0;
      endcase
    end
  end

  always_comb begin
    dig_d     = dig_q;
    led_d     = led_q;
    sw_meta_d = sw_i;
    sw_sync_d = sw_meta_q;
    tick      = (tpre_q == TDIV_LAST);
    tpre_d    = tick ? 32'h0 : tpre_q + 32'h1;
    timer_d   = tick ? timer_q + 32'h1 : timer_q;
    if (io_wr) begin
      case (word_off)
        OFF_DIG[11:2]: dig_d = wdata_i;
        OFF_TIMER[11:2]: begin
          // Write overrides a coincident tick and restarts the prescaler.
          timer_d = wdata_i;
          tpre_d  = 32'h0;
        end
        OFF_LED[11:2]: led_d = wdata_i[23:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_q     <= '0;
      led_q     <= '0;
      timer_q   <= '0;
      tpre_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      dig_q     <= dig_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      tpre_q    <= tpre_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  assign led_o = led_q;

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .dig_i   (dig_q),
    .seg_en_o(seg_en_o),
    .seg_o   (seg_o)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with SCAN_DIV=4, TIMER_DIV=1.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        we_i = 1'b0;
  logic [31:0] rdata_o;
  logic [15:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_we_o;
  logic [31:0] ram_rdata_i = 32'h0;
  logic [23:0] sw_i = 24'h0;
  logic [23:0] led_o;
  logic [7:0]  seg_en_o;
  logic [7:0]  seg_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mmio_bridge #(
    .RAM_AW(16),
    .SCAN_DIV(4),
    .TIMER_DIV(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i),
    .rdata_o(rdata_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_we_o(ram_we_o), .ram_rdata_i(ram_rdata_i), .sw_i(sw_i), .led_o(led_o),
    .seg_en_o(seg_en_o), .seg_o(seg_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we_i = 1'b0; addr_i = 32'hFFFFF020;
    step(); step();
    tests_run++;
    if (led_o !== 24'h0) begin tests_failed++; $display("FAIL reset_led got=%h exp=%h", led_o, 24'h0); end
    tests_run++;
    if (seg_en_o !== 8'hFE) begin tests_failed++; $display("FAIL reset_seg_en got=%h exp=%h", seg_en_o, 8'hFE); end
    tests_run++;
    if (seg_o !== 8'hC0) begin tests_failed++; $display("FAIL reset_seg got=%h exp=%h", seg_o, 8'hC0); end
    #1;
    tests_run++;
    if (rdata_o !== 32'h0) begin tests_failed++; $display("FAIL reset_timer_read got=%h exp=%h", rdata_o, 32'h0); end
    addr_i = 32'h0000_0124; #1;
    tests_run++;
    if (ram_addr_o !== 16'h0049) begin tests_failed++; $display("FAIL reset_ram_addr got=%h exp=%h", ram_addr_o, 16'h0049); end
    $display("[TB] reset: state checked");
  endtask

  task automatic test_scan();
    int idx;
    logic [7:0] exp_en, exp_seg;
    rst_n = 1'b0; we_i = 1'b0;
    step();
    // release reset with a DIG write in the same cycle
    rst_n = 1'b1; addr_i = 32'hFFFFF000; wdata_i = 32'h0000000F; we_i = 1'b1;
    for (int k = 0; k < 36; k++) begin
      step();
      we_i = 1'b0;
      idx = ((k + 1) / 4) % 8;
      exp_en = 8'hFF; exp_en[idx] = 1'b0;
      exp_seg = (idx == 0) ? 8'h8E : 8'hC0;
      tests_run++;
      if (seg_en_o !== exp_en) begin tests_failed++; $display("FAIL scan_en k=%0d got=%h exp=%h", k, seg_en_o, exp_en); end
      tests_run++;
      if (seg_o !== exp_seg) begin tests_failed++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg_o, exp_seg); end
    end
    // mid-scan DIG write while digit 1 is lit: nibble 1 = A
    wdata_i = 32'h000000A0; we_i = 1'b1;
    step();
    we_i = 1'b0;
    tests_run++;
    if (seg_en_o !== 8'hFD) begin tests_failed++; $display("FAIL scan_mid_en got=%h exp=%h", seg_en_o, 8'hFD); end
    tests_run++;
    if (seg_o !== 8'h88) begin tests_failed++; $display("FAIL scan_mid_seg got=%h exp=%h", seg_o, 8'h88); end
    #1;
    tests_run++;
    if (rdata_o !== 32'h000000A0) begin tests_failed++; $display("FAIL dig_read got=%h exp=%h", rdata_o, 32'h000000A0); end
    $display("[TB] scan: 37 cycles checked");
  endtask

  task automatic test_led();
    addr_i = 32'hFFFFF060; wdata_i = 32'h00ABCDEF; we_i = 1'b1; #1;
    tests_run++;
    if (ram_we_o !== 1'b0) begin tests_failed++; $display("FAIL led_ram_we got=%b exp=%b", ram_we_o, 1'b0); end
    step();
    we_i = 1'b0; #1;
    tests_run++;
    if (led_o !== 24'hABCDEF) begin tests_failed++; $display("FAIL led_out got=%h exp=%h", led_o, 24'hABCDEF); end
    tests_run++;
    if (rdata_o !== 32'h00ABCDEF) begin tests_failed++; $display("FAIL led_read got=%h exp=%h", rdata_o, 32'h00ABCDEF); end
    $display("[TB] led: store 0x00ABCDEF");
  endtask

  task automatic test_ram();
    addr_i = 32'h00000010; wdata_i = 32'h00001234; we_i = 1'b1; #1;
    tests_run++;
    if (ram_we_o !== 1'b1) begin tests_failed++; $display("FAIL ram_we got=%b exp=%b", ram_we_o, 1'b1); end
    tests_run++;
    if (ram_addr_o !== 16'h0004) begin tests_failed++; $display("FAIL ram_addr got=%h exp=%h", ram_addr_o, 16'h0004); end
    tests_run++;
    if (ram_wdata_o !== 32'h00001234) begin tests_failed++; $display("FAIL ram_wdata got=%h exp=%h", ram_wdata_o, 32'h00001234); end
    step();
    we_i = 1'b0; ram_rdata_i = 32'h00000055; #1;
    tests_run++;
    if (rdata_o !== 32'h00000055) begin tests_failed++; $display("FAIL ram_read got=%h exp=%h", rdata_o, 32'h00000055); end
    tests_run++;
    if (led_o !== 24'hABCDEF) begin tests_failed++; $display("FAIL ram_no_io got=%h exp=%h", led_o, 24'hABCDEF); end
    $display("[TB] ram: store 0x1234 to 0x10, load 0x55");
  endtask

  task automatic test_unmapped();
    addr_i = 32'hFFFFF040; wdata_i = 32'hDEADBEEF; we_i = 1'b1; #1;
    tests_run++;
    if (ram_we_o !== 1'b0) begin tests_failed++; $display("FAIL unmapped_ram_we got=%b exp=%b", ram_we_o, 1'b0); end
    step();
    we_i = 1'b0; #1;
    tests_run++;
    if (rdata_o !== 32'h0) begin tests_failed++; $display("FAIL unmapped_read got=%h exp=%h", rdata_o, 32'h0); end
    $display("[TB] unmapped: offset 0x040");
  endtask

  task automatic test_sw();
    addr_i = 32'hFFFFF070; sw_i = 24'h00F00F; #1;
    tests_run++;
    if (rdata_o !== 32'h0) begin tests_failed++; $display("FAIL sw_edge0 got=%h exp=%h", rdata_o, 32'h0); end
    step();
    tests_run++;
    if (rdata_o !== 32'h0) begin tests_failed++; $display("FAIL sw_edge1 got=%h exp=%h", rdata_o, 32'h0); end
    step();
    tests_run++;
    if (rdata_o !== 32'h0000F00F) begin tests_failed++; $display("FAIL sw_edge2 got=%h exp=%h", rdata_o, 32'h0000F00F); end
    $display("[TB] sw: 0x00F00F");
  endtask

  task automatic test_timer();
    addr_i = 32'hFFFFF020; wdata_i = 32'hFFFFFFFF; we_i = 1'b1;
    step();
    we_i = 1'b0; #1;
    tests_run++;
    if (rdata_o !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL timer_write got=%h exp=%h", rdata_o, 32'hFFFFFFFF); end
    step();
    tests_run++;
    if (rdata_o !== 32'h0) begin tests_failed++; $display("FAIL timer_wrap got=%h exp=%h", rdata_o, 32'h0); end
    step();
    tests_run++;
    if (rdata_o !== 32'h1) begin tests_failed++; $display("FAIL timer_inc got=%h exp=%h", rdata_o, 32'h1); end
    wdata_i = 32'h00000100; we_i = 1'b1;
    step();
    we_i = 1'b0; #1;
    tests_run++;
    if (rdata_o !== 32'h00000100) begin tests_failed++; $display("FAIL timer_write_wins got=%h exp=%h", rdata_o, 32'h00000100); end
    step();
    tests_run++;
    if (rdata_o !== 32'h00000101) begin tests_failed++; $display("FAIL timer_after got=%h exp=%h", rdata_o, 32'h00000101); end
    $display("[TB] timer: wrap and write-vs-tick");
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; addr_i = 32'hFFFFF060; wdata_i = 32'h00123456; we_i = 1'b1;
    step();
    tests_run++;
    if (led_o !== 24'h0) begin tests_failed++; $display("FAIL rst_mid_led got=%h exp=%h", led_o, 24'h0); end
    we_i = 1'b0; addr_i = 32'hFFFFF020; #1;
    tests_run++;
    if (rdata_o !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_timer got=%h exp=%h", rdata_o, 32'h0); end
    tests_run++;
    if (seg_en_o !== 8'hFE) begin tests_failed++; $display("FAIL rst_mid_seg_en got=%h exp=%h", seg_en_o, 8'hFE); end
    rst_n = 1'b1;
    $display("[TB] reset mid-operation");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_led();
    test_ram();
    test_unmapped();
    test_sw();
    test_timer();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
